serial_add_ctrl: RTL



---
 rtl/serial_add_pkg.sv | 29 ++
 rtl/full_adder.sv | 26 ++
 rtl/serial_add_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Purpose : shared types and constants for the bit-serial adder controller.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: controller state encoding, default operand width and the
// bit-counter width helper used to size the RUN-phase counter.
package serial_add_pkg;

  // Default operand/sum width used when the top is instantiated without override.
  localparam int SA_DEF_WIDTH = 8;

  // Controller states. Explicit encodings keep waveforms and any legacy
  // decode logic stable across tool versions.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a counter that must reach w-1. Clamped to at least one bit so
  // the counter is always a legal vector.
  function automatic int cnt_width(input int w);
    if (w < 2) begin
      return 1;
    end
    return $clog2(w);
  endfunction

endpackage : serial_add_pkg

// File: rtl/full_adder.sv
// Purpose : single-bit full adder, the shared datapath cell of the serial adder.
// Latency : purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
//
// Ports:
//   a_i, b_i : addend bits
//   c_i      : carry in
//   s_o      : sum bit
//   co_o     : carry out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic half_s;

  assign half_s = a_i ^ b_i;
  assign s_o    = half_s ^ c_i;
  // Generate when both addend bits are set, propagate the incoming carry
  // when exactly one is set.
  assign co_o   = (a_i & b_i) | (c_i & half_s);

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial WIDTH-bit unsigned adder sharing one full_adder, LSB first.
// Latency : WIDTH cycles from start acceptance to the done_out cycle; WIDTH+2 per add.
// Backpressure: start_in is only taken while ready_out=1; starts seen while busy are dropped.
//
// Ports:
//   clk_in    : clock, rising edge
//   rst_in    : synchronous active-high reset (wins over start_in)
//   start_in  : add request, accepted when ready_out=1
//   a_in/b_in : operands, sampled on acceptance only
//   c_in      : carry-in, sampled on acceptance only
//   ready_out : high while idle
//   done_out  : one-cycle pulse when sum_out/carry_out hold a fresh result
//   sum_out   : WIDTH-bit sum, held until the next publish
//   carry_out : final carry, held with sum_out
//   ovf_out   : two's-complement overflow, only when SERIAL_ADD_OVF_EN is defined
//
// Build option: define SERIAL_ADD_OVF_EN to add the ovf_out port and its logic.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_DEF_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 most recently produced sum bits. The final bit comes
  // straight from the adder on the publish edge, so a full WIDTH-bit shift
  // register would carry one bit that is never read.
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // ---------------------------------------------------------------------------
  // Shared datapath cell
  // ---------------------------------------------------------------------------
  logic fa_s;
  logic fa_co;

  full_adder u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // Sum bits including the one being produced this cycle, MSB-aligned.
  // On the last RUN cycle this is the complete result.
  logic [WIDTH-1:0] sum_full;
  assign sum_full = {fa_s, sum_sh_q};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          a_sh_d   = a_in;
          b_sh_d   = b_in;
          carry_d  = c_in;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // New bit enters at the MSB end; after WIDTH shifts the first
        // (LSB) result bit has reached position 0.
        sum_sh_d = sum_full[WIDTH-1:1];
        carry_d  = fa_co;
        if (cnt_q == CNT_LAST) begin
          sum_d   = sum_full;
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this final step.
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready_out = (state_q == ST_IDLE);
  assign done_out  = (state_q == ST_DONE);
  assign sum_out   = sum_q;
  assign carry_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf_out   = ovf_q;
`endif

endmodule : serial_add_ctrl
